// File: rtl/morse_tone_player.sv
// Purpose: plays a latched Morse on/off pattern (bit 0 first) as a square-wave tone,
//          one pattern bit per UNIT_CYC cycles, one-shot or looped with a silent gap.
// Latency: first beep-eligible cycle is the cycle after start is accepted; a pass is len_eff*UNIT_CYC cycles.
// Backpressure: none; start is taken only in IDLE, start while busy is dropped, abort wins over start.
//
// Ports:
//   clk      - clock, all logic on the rising edge
//   rst      - synchronous reset, active-low
//   start    - request playback (sampled in IDLE only)
//   pattern  - on/off bits, latched on an accepted start
//   len      - bits to play, latched (clamped to PAT_W) on an accepted start
//   loop_en  - loop mode, sampled at the end of each pass
//   abort    - stop playback on the next edge, no done pulse
//   busy     - high in PLAY or GAP
//   done     - one-cycle pulse on normal completion (or on a len=0 start)
//   bit_idx  - index of the bit currently playing (0 outside PLAY)
//   beep     - tone output to the buzzer
module morse_tone_player #(
  parameter int PAT_W     = 75,
  parameter int LEN_W     = 7,
  parameter int UNIT_CYC  = 12000000,
  parameter int TONE_HALF = 50000,
  parameter int GAP_UNITS = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic             loop_en,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] bit_idx,
  output logic             beep
);

  localparam int GAP_CYC = UNIT_CYC * GAP_UNITS;
  // unit_cnt also times the gap, so it is sized for the longer of the two intervals.
  localparam int UW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int TW = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;

  localparam logic [UW-1:0]    UNIT_LAST = UW'(UNIT_CYC - 1);
  localparam logic [UW-1:0]    GAP_LAST  = UW'(GAP_CYC - 1);
  localparam logic [TW-1:0]    TONE_LAST = TW'(TONE_HALF - 1);
  localparam logic [LEN_W-1:0] PAT_MAX   = LEN_W'(PAT_W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] bit_idx_q;
  logic [UW-1:0]    unit_cnt;
  logic [TW-1:0]    tone_cnt;
  logic             tone_q;
  logic             done_q;

  logic             accept;
  logic             bit_end;
  logic             last_bit;
  logic             gap_end;
  logic [LEN_W-1:0] len_eff;

  assign accept   = (state_q == S_IDLE) & start & ~abort;
  assign bit_end  = (state_q == S_PLAY) & (unit_cnt == UNIT_LAST);
  assign last_bit = (bit_idx_q == (len_q - LEN_W'(1)));
  assign gap_end  = (state_q == S_GAP) & (unit_cnt == GAP_LAST);
  assign len_eff  = (len > PAT_MAX) ? PAT_MAX : len;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept && (len != '0)) begin
          state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (bit_end && last_bit) begin
          state_d = loop_en ? S_GAP : S_IDLE;
        end
      end
      S_GAP: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (gap_end) begin
          state_d = S_PLAY;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pattern latch, bit/unit/tone counters and the done pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pat_q     <= '0;
      len_q     <= '0;
      bit_idx_q <= '0;
      unit_cnt  <= '0;
      tone_cnt  <= '0;
      tone_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (len == '0) begin
              // Empty request: acknowledge without playing anything.
              done_q <= 1'b1;
            end else begin
              pat_q     <= pattern;
              len_q     <= len_eff;
              bit_idx_q <= '0;
              unit_cnt  <= '0;
              tone_cnt  <= '0;
              tone_q    <= 1'b1;
            end
          end
        end
        S_PLAY: begin
          if (abort) begin
            bit_idx_q <= '0;
            unit_cnt  <= '0;
            tone_cnt  <= '0;
            tone_q    <= 1'b0;
          end else if (bit_end) begin
            // Every bit starts with a fresh tone phase so each beep sounds identical.
            unit_cnt <= '0;
            tone_cnt <= '0;
            tone_q   <= 1'b1;
            if (last_bit) begin
              bit_idx_q <= '0;
              done_q    <= ~loop_en;
            end else begin
              bit_idx_q <= bit_idx_q + LEN_W'(1);
            end
          end else begin
            unit_cnt <= unit_cnt + UW'(1);
            if (tone_cnt == TONE_LAST) begin
              tone_cnt <= '0;
              tone_q   <= ~tone_q;
            end else begin
              tone_cnt <= tone_cnt + TW'(1);
            end
          end
        end
        S_GAP: begin
          if (abort) begin
            unit_cnt <= '0;
            tone_cnt <= '0;
            tone_q   <= 1'b0;
          end else if (gap_end) begin
            unit_cnt <= '0;
            tone_cnt <= '0;
            tone_q   <= 1'b1;
          end else begin
            unit_cnt <= unit_cnt + UW'(1);
          end
        end
        default: begin
          unit_cnt <= '0;
        end
      endcase
    end
  end

  // Outputs: purely from registered state, no input-to-output path.
  always_comb begin
    busy    = (state_q != S_IDLE);
    done    = done_q;
    bit_idx = bit_idx_q;
    beep    = (state_q == S_PLAY) & tone_q & (|(pat_q & (PAT_W'(1) << bit_idx_q)));
  end

endmodule

// File: tb/tb_morse_tone_player.sv
// Purpose: scoreboard bench for morse_tone_player; a cycle-level reference model derives
//          expected outputs from elapsed time within a pass, a monitor compares every cycle.
// Latency: expectations are pushed one cycle ahead of the edge at which they apply.
// Backpressure: not applicable.
module tb_morse_tone_player;

  localparam int PAT_W     = 8;
  localparam int LEN_W     = 4;
  localparam int UNIT_CYC  = 4;
  localparam int TONE_HALF = 1;
  localparam int GAP_UNITS = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [PAT_W-1:0] pattern = '0;
  logic [LEN_W-1:0] len = '0;
  logic             loop_en = 1'b0;
  logic             abort = 1'b0;
  logic             busy;
  logic             done;
  logic [LEN_W-1:0] bit_idx;
  logic             beep;

  morse_tone_player #(
    .PAT_W    (PAT_W),
    .LEN_W    (LEN_W),
    .UNIT_CYC (UNIT_CYC),
    .TONE_HALF(TONE_HALF),
    .GAP_UNITS(GAP_UNITS)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .pattern(pattern),
    .len    (len),
    .loop_en(loop_en),
    .abort  (abort),
    .busy   (busy),
    .done   (done),
    .bit_idx(bit_idx),
    .beep   (beep)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  int cyc = 0;

  // Expected vector: {busy, done, bit_idx[3:0], beep}
  logic [6:0] exp_q[$];

  // Reference model: mode 0=idle 1=playing 2=gap, t = cycles elapsed in the current pass or gap.
  int             m_mode = 0;
  int             m_t = 0;
  int             m_len = 0;
  logic [PAT_W-1:0] m_pat = '0;
  bit             m_done = 1'b0;

  task automatic model_step();
    m_done = 1'b0;
    if (!rst) begin
      m_mode = 0;
      m_t    = 0;
      m_len  = 0;
      m_pat  = '0;
    end else begin
      case (m_mode)
        0: begin
          if (start && !abort) begin
            if (len == 0) begin
              m_done = 1'b1;
            end else begin
              m_pat  = pattern;
              m_len  = (int'(len) > PAT_W) ? PAT_W : int'(len);
              m_mode = 1;
              m_t    = 0;
            end
          end
        end
        1: begin
          if (abort) begin
            m_mode = 0;
            m_t    = 0;
          end else begin
            m_t++;
            if (m_t == m_len * UNIT_CYC) begin
              m_t = 0;
              if (loop_en) begin
                m_mode = 2;
              end else begin
                m_mode = 0;
                m_done = 1'b1;
              end
            end
          end
        end
        default: begin
          if (abort) begin
            m_mode = 0;
            m_t    = 0;
          end else begin
            m_t++;
            if (m_t == GAP_UNITS * UNIT_CYC) begin
              m_t    = 0;
              m_mode = 1;
            end
          end
        end
      endcase
    end
  endtask

  function automatic logic [6:0] model_out();
    int   bi;
    logic b;
    logic bp;
    b  = (m_mode != 0);
    bi = (m_mode == 1) ? (m_t / UNIT_CYC) : 0;
    bp = (m_mode == 1) && m_pat[bi] && ((((m_t % UNIT_CYC) / TONE_HALF) % 2) == 0);
    return {b, m_done, 4'(bi), bp};
  endfunction

  // Apply one cycle of inputs and queue the outputs they should produce after the next edge.
  task automatic drive(input logic r, input logic s, input logic a, input logic l,
                       input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] n);
    @(negedge clk);
    rst     = r;
    start   = s;
    abort   = a;
    loop_en = l;
    pattern = p;
    len     = n;
    model_step();
    exp_q.push_back(model_out());
  endtask

  task automatic idle_n(input int n, input logic l);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, l, 8'h00, 4'd0);
  endtask

  task automatic check(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, want);
    end
  endtask

  task automatic clear_counts();
    busy_cnt = 0;
    done_cnt = 0;
  endtask

  // Waits for the last queued cycle to be checked, then compares scenario totals.
  task automatic scen_check(input string name, input int want_busy, input int want_done);
    @(posedge clk);
    #3;
    check({name, "_busy_cycles"}, busy_cnt, want_busy);
    check({name, "_done_pulses"}, done_cnt, want_done);
  endtask

  // Monitor: every cycle with a pending expectation is compared field by field.
  initial begin
    logic [6:0] e;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("busy",    int'(busy),    int'(e[6]));
        check("done",    int'(done),    int'(e[5]));
        check("bit_idx", int'(bit_idx), int'(e[4:1]));
        check("beep",    int'(beep),    int'(e[0]));
        if (busy) busy_cnt++;
        if (done) done_cnt++;
      end
    end
  end

  initial begin
    int guard;
    // Reset with start held high: must be ignored.
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 4'd3);
    idle_n(2, 1'b0);

    // One-shot, pattern 101, 3 bits.
    clear_counts();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'b0000_0101, 4'd3);
    idle_n(14, 1'b0);
    scen_check("oneshot", 12, 1);

    // Empty request.
    clear_counts();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'b0000_0101, 4'd0);
    idle_n(3, 1'b0);
    scen_check("empty", 0, 1);

    // Abort and start in the same idle cycle: nothing starts.
    clear_counts();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 8'b0000_0101, 4'd3);
    idle_n(3, 1'b0);
    scen_check("abort_vs_start", 0, 0);

    // Loop: two passes with a gap, loop_en dropped during the second pass.
    clear_counts();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 8'b0000_0101, 4'd3);
    idle_n(24, 1'b1);
    idle_n(14, 1'b0);
    scen_check("loop", 32, 1);

    // Abort on cycle 2, fresh start on cycle 3.
    clear_counts();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'b0000_0101, 4'd3);
    idle_n(1, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'b0000_0101, 4'd3);
    idle_n(14, 1'b0);
    scen_check("abort", 14, 1);

    // Reset at cycle 6 of playback with start held, then a normal replay.
    clear_counts();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'b0000_0101, 4'd3);
    idle_n(5, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 4'd3);
    idle_n(2, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'b0000_0101, 4'd3);
    idle_n(14, 1'b0);
    scen_check("reset", 18, 1);

    // Length clamp and start-while-busy ignored.
    clear_counts();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 4'd12);
    idle_n(4, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 4'd2);
    idle_n(35, 1'b0);
    scen_check("clamp", 32, 1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 199) != 0),
            ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 2) != 0),
            8'($urandom),
            4'($urandom_range(0, 15)));
    end
    idle_n(4, 1'b0);

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      #3;
      guard++;
    end
    check("drain_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/morse_tone_player.md
Name: morse_tone_player

Overview:
Parametrised successor to the fixed-width buzzer driver. It plays a latched Morse on/off pattern onto a square-wave tone output, bit by bit, at a programmable unit time. It offers one-shot or looped playback with an inter-repeat gap, a start/busy/done handshake and abort. It sits between the encoder/pattern source and the board buzzer pin.

Parameters:
PAT_W, 75, maximum pattern length in bits.
LEN_W, 7, width of the length input; must satisfy 2^LEN_W > PAT_W.
UNIT_CYC, 12000000, clock cycles per pattern bit (one Morse unit); must be >= 1.
TONE_HALF, 50000, clock cycles per tone half-period; must be >= 1.
GAP_UNITS, 7, silent units inserted between repeats in loop mode; must be >= 1.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst  input  1  synchronous reset, active-low.
start  input  1  request playback; sampled in IDLE only.
pattern  input  PAT_W  on/off bits; bit 0 is played first; latched on an accepted start.
len  input  LEN_W  number of bits to play; latched on an accepted start.
loop_en  input  1  loop mode; sampled live at the end of each pass.
abort  input  1  stop playback immediately.
busy  output  1  high while in PLAY or GAP.
done  output  1  one-cycle pulse on normal completion.
bit_idx  output  LEN_W  index of the bit currently playing.
beep  output  1  tone output to the buzzer.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst. While rst=0 at a clock edge: state=IDLE, all counters 0, pattern register 0, tone_q=0. Outputs busy=0, done=0, bit_idx=0, beep=0. Inputs are ignored, including start. A reset in the middle of playback aborts it with no done pulse.
- States:
  - IDLE: waits for start.
  - PLAY: plays pattern bits.
  - GAP: silent interval between repeats.
- Start handling:
  - In IDLE with start=1 and abort=0: if len=0, no playback occurs; done=1 on the next cycle and the block stays in IDLE.
  - Otherwise latch pattern and len_eff = min(len, PAT_W), then enter PLAY with bit_idx=0.
  - start while busy is ignored.
  - If abort=1 and start=1 in the same IDLE cycle, abort wins and nothing starts.
- PLAY:
  - Each bit lasts exactly UNIT_CYC cycles, counted by unit_cnt from 0 to UNIT_CYC-1.
  - At each bit start the tone phase restarts: tone_q=1 and tone_cnt=0. tone_q toggles every TONE_HALF cycles within the bit.
  - beep = (state==PLAY) & pat_q[bit_idx] & tone_q. It is combinational from registered state only, with no input-to-output path.
  - When the last bit (bit_idx = len_eff-1) completes:
    - loop_en=1: enter GAP.
    - loop_en=0: enter IDLE with done=1 for that single cycle; busy=0 in the same cycle.
- GAP:
  - Lasts GAP_UNITS*UNIT_CYC cycles with beep=0 and bit_idx held at 0.
  - Then enter PLAY at bit 0 with the same latched pattern. No new start is needed.
- abort=1 in PLAY or GAP: the next cycle is IDLE with busy=0, beep=0 and no done pulse.
- Counter widths:
  - unit_cnt sized by $clog2(UNIT_CYC*GAP_UNITS).
  - tone_cnt sized by $clog2(TONE_HALF).
- Total latency: the first beep-eligible cycle is the cycle after start is accepted. A one-shot pass occupies exactly len_eff*UNIT_CYC busy cycles.

Test Plan:
Use PAT_W=8, LEN_W=4, UNIT_CYC=4, TONE_HALF=1, GAP_UNITS=2 for all scenarios.
- One-shot: pattern=8'b00000101, len=3, loop_en=0, start at cycle 0 -> busy on cycles 1-12. beep=1,0,1,0 on cycles 1-4, 0 on cycles 5-8, 1,0,1,0 on cycles 9-12. bit_idx=0/1/2 per 4-cycle block. done=1 only on cycle 13, with busy=0 on cycle 13.
- Empty: len=0, start at cycle 0 -> done=1 on cycle 1; busy and beep stay 0.
- Loop: same pattern with loop_en=1 -> after cycle 12, 8 cycles of GAP (beep=0, busy=1), then bit 0 replays from cycle 21. Drop loop_en during the second pass -> done pulses after that pass ends; no further GAP.
- Abort: abort asserted on cycle 2 of one-shot playback -> from cycle 3 busy=0 and beep=0, with no done pulse. A start on cycle 3 then begins a fresh playback.
- Reset: rst=0 at cycle 6 of playback -> at the next edge all outputs are 0. start held high during reset is ignored. After release, a start pulse plays normally.
- Clamp and ignore: len=12 with pattern=8'hFF -> exactly 8 bits (32 busy cycles). A second start with a different pattern asserted mid-play is ignored; output follows the first pattern.
